// File: rtl/weight_pkg.sv
// Shared types and constants for the weight fetch path.
//   word_t     : default-width two's-complement weight word (Q6.7)
//   ADDR_BITS  : default column ROM address width
//   state_t    : fetch sequencer states
package weight_pkg;

    localparam int unsigned INT_BITS_DEF = 6;
    localparam int unsigned FRC_BITS_DEF = 7;
    localparam int unsigned DEPTH_DEF    = 32;
    localparam int unsigned WORD_BITS    = INT_BITS_DEF + FRC_BITS_DEF;
    localparam int unsigned ADDR_BITS    = $clog2(DEPTH_DEF);

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry FIFO between the ROM read pipeline and the MAC stream.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   push, push_data/last     : write one word (with its last tag)
//   pop                      : remove the head word (ignored when empty)
//   head_valid/data/last     : registered head of the FIFO
//   level_c                  : combinational occupancy, 0..2
module weight_skid_buf #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output logic [1:0]   level_c
);

    logic         tail_valid;
    logic [W-1:0] tail_data;
    logic         tail_last;
    logic         pop_eff;

    assign pop_eff = pop && head_valid;
    assign level_c = {1'b0, head_valid} + {1'b0, tail_valid};

    // Head/tail shift register; push and pop may coincide at any level.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_last  <= 1'b0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
            tail_last  <= 1'b0;
        end else begin
            case ({push, pop_eff})
                2'b01: begin
                    head_valid <= tail_valid;
                    head_data  <= tail_data;
                    head_last  <= tail_last;
                    tail_valid <= 1'b0;
                end
                2'b10: begin
                    if (!head_valid) begin
                        head_valid <= 1'b1;
                        head_data  <= push_data;
                        head_last  <= push_last;
                    end else if (!tail_valid) begin
                        tail_valid <= 1'b1;
                        tail_data  <= push_data;
                        tail_last  <= push_last;
                    end
                end
                2'b11: begin
                    if (tail_valid) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end else begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch.sv
// Burst reader: streams len consecutive weight words from a column ROM
// (one-cycle read latency) to the MAC over a valid/ready handshake.
// Optional build macro WEIGHT_FETCH_CHECKSUM_EN adds a burst checksum.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, len           : burst request (len clamped to DEPTH, 0 = empty)
//   rom_addr, rom_dout   : column ROM read port
//   m_valid/ready/data/last : weight stream to the MAC
//   busy, done           : burst in progress / one-cycle completion pulse
//   csum (macro only)    : signed sum of accepted words, valid with done
module weight_fetch
    import weight_pkg::*;
#(
    parameter  int unsigned INT_BITS = INT_BITS_DEF,
    parameter  int unsigned FRC_BITS = FRC_BITS_DEF,
    parameter  int unsigned DEPTH    = DEPTH_DEF,
    localparam int unsigned W        = INT_BITS + FRC_BITS,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic [AW-1:0] rom_addr,
    input  logic [W-1:0]  rom_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    ,
    output logic signed [W+AW-1:0] csum
`endif
);

    state_t        state;
    logic [AW-1:0] last_addr;
    logic          inflight;
    logic          inflight_last;

    logic [AW:0]   len_clamp_c;
    logic [AW-1:0] last_addr_c;
    logic [1:0]    level_c;
    logic          pop_c;
    logic          issue_c;

    assign len_clamp_c = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign last_addr_c = AW'(len_clamp_c - (AW+1)'(1));
    assign pop_c       = m_valid && m_ready;

    // rom_addr is registered one step ahead: the cycle a read is issued is the
    // cycle its address is on rom_addr, and its data lands in the FIFO one
    // cycle later. A slot being popped this cycle counts as free, which is
    // what allows a word every cycle with only two entries.
    assign issue_c = (state == FETCH) &&
                     (({1'b0, level_c} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop_c}));

    weight_skid_buf #(.W(W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (rom_dout),
        .push_last  (inflight_last),
        .pop        (pop_c),
        .head_valid (m_valid),
        .head_data  (m_data),
        .head_last  (m_last),
        .level_c    (level_c)
    );

    // Burst sequencer, address counter and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rom_addr      <= '0;
            last_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue_c;
            inflight_last <= issue_c && (rom_addr == last_addr);
            // Address holds on the final read of the burst.
            if (issue_c && (rom_addr != last_addr)) begin
                rom_addr <= rom_addr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            rom_addr  <= '0;
                            last_addr <= last_addr_c;
                        end
                    end
                end
                FETCH: begin
                    if (issue_c && (rom_addr == last_addr)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_c && m_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_FETCH_CHECKSUM_EN
    // Running sum of accepted words, sign-extended to W+AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if (pop_c) begin
            csum <= csum + $signed({{AW{m_data[W-1]}}, m_data});
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch with a registered ROM model
// (rom_dout = 0x030 + rom_addr, one cycle latency).
module tb_weight_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  len;
    logic [4:0]  rom_addr;
    logic [12:0] rom_dout;
    logic        m_valid;
    logic        m_ready;
    logic [12:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    logic signed [17:0] csum;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= 13'h030 + {8'h00, rom_addr};

    weight_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done)
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst; mode 0 holds m_ready high, mode 1 uses a 1,0,0,1 pattern.
    task automatic run_burst(input int len_in, input int mode, input int exp_words);
        int          idx;
        int          cyc;
        bit          seen_done;
        bit          prev_stall;
        logic [12:0] prev_data;
        logic        prev_last;
        idx = 0; cyc = 0; seen_done = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        start = 1'b1;
        len   = 6'(len_in);
        tick();
        start = 1'b0;
        while (cyc < 500) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (prev_stall) begin
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                check("data", 32'(m_data), 32'(13'h030 + 13'(idx)));
                check("last", 32'(m_last), 32'(idx == exp_words - 1));
                idx++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            tick();
            cyc++;
        end
        check("done_seen", 32'(seen_done), 32'd1);
        check("word_count", 32'(idx), 32'(exp_words));
        check("valid_at_done", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        if (len_in == 0) begin
            check("busy_at_done_len0", 32'(busy), 32'd1);
        end
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        int cyc;
        rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        tick();

        // len=4, ready high: two-cycle latency then one word per cycle.
        start = 1'b1; len = 6'd4;
        tick();
        start = 1'b0;
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid0", 32'(m_valid), 32'd0);
        start = 1'b1; len = 6'd1;   // ignored while busy
        tick();
        start = 1'b0;
        check("lat_valid1", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b4_valid", 32'(m_valid), 32'd1);
            check("b4_data", 32'(m_data), 32'(13'h030 + 13'(i)));
            check("b4_last", 32'(m_last), 32'(i == 3));
            check("b4_nodone", 32'(done), 32'd0);
        end
        tick();
        check("b4_done", 32'(done), 32'd1);
        check("b4_valid_end", 32'(m_valid), 32'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        check("b4_csum", 32'(csum), 32'h0C6);
`endif
        tick();
        check("b4_done_end", 32'(done), 32'd0);
        check("b4_idle", 32'(busy), 32'd0);

        run_burst(32, 1, 32);
        run_burst(0, 0, 0);
        run_burst(40, 0, 32);
        run_burst(5, 1, 5);

        // Abort a len=16 burst after the 5th accepted word.
        m_ready = 1'b1;
        start = 1'b1; len = 6'd16;
        tick();
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 5 && cyc < 100) begin
            if (m_valid) cnt++;
            tick();
            cyc++;
        end
        check("abort_reached5", 32'(cnt), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_data", 32'(m_data), 32'd0);
        check("abort_last", 32'(m_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(rom_addr), 32'd0);
        tick();
        check("abort_quiet", 32'(m_valid), 32'd0);
        run_burst(2, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
